// File: rtl/ppc_types.sv
// Shared types for the out-of-order core: unit decode payloads and the
// operand record held in reservation-station entries.
package ppc_types;

  // Tags are stored zero-extended to this width; RS_ID_WIDTH must not exceed it.
  localparam int unsigned MaxTagWidth = 8;

  typedef struct packed {
    logic       subtract;
    logic [4:0] dest;
  } add_sub_decode_t;

  typedef struct packed {
    logic [31:0]            value;
    logic                   present;
    logic [MaxTagWidth-1:0] tag;
  } operand_t;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit priority encoder: returns the index of the lowest asserted
// request and whether any request is asserted.
module priority_encoder #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands arrive on the
// result bus, then offers the lowest ready entry to the execution unit.
module reservation_station
  import ppc_types::*;
#(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned RS_OFFSET   = 1,
  parameter int unsigned RS_DEPTH    = 4,
  parameter type         OPCODE_TYPE = add_sub_decode_t
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        input_valid,
  output logic                        input_ready,
  input  OPCODE_TYPE                  op_decode,
  input  logic [1:0][31:0]            op_value,
  input  logic [1:0]                  op_value_valid,
  input  logic [1:0][RS_ID_WIDTH-1:0] op_tag,
  output logic [RS_ID_WIDTH-1:0]      id,
  input  logic                        result_valid,
  input  logic [RS_ID_WIDTH-1:0]      result_tag,
  input  logic [31:0]                 result_value,
  output logic                        output_valid,
  input  logic                        output_ready,
  output OPCODE_TYPE                  output_decode,
  output logic [31:0]                 output_op_a,
  output logic [31:0]                 output_op_b,
  output logic [RS_ID_WIDTH-1:0]      output_id
);

  localparam int unsigned IdxW = $clog2(RS_DEPTH);
  typedef logic [IdxW-1:0] idx_t;

  logic [RS_DEPTH-1:0] busy_q, busy_d;
  operand_t [1:0]      opnd_q   [RS_DEPTH];
  operand_t [1:0]      opnd_d   [RS_DEPTH];
  OPCODE_TYPE          decode_q [RS_DEPTH];
  OPCODE_TYPE          decode_d [RS_DEPTH];
  logic                lock_q, lock_d;
  idx_t                lock_idx_q, lock_idx_d;

  logic [RS_DEPTH-1:0] issuable;
  idx_t                free_idx, pe_issue_idx, sel_idx;
  logic                free_found, accept, issue, res_hit;
  logic [MaxTagWidth-1:0] res_tag_ext;

  always_comb begin
    issuable = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      issuable[i] = busy_q[i] & opnd_q[i][0].present & opnd_q[i][1].present;
    end
  end

  priority_encoder #(.WIDTH(RS_DEPTH)) u_free_sel (
    .req_i   (~busy_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  priority_encoder #(.WIDTH(RS_DEPTH)) u_issue_sel (
    .req_i   (issuable),
    .idx_o   (pe_issue_idx),
    .found_o (output_valid)
  );

  // A stalled offer stays pinned so the payload cannot change under the consumer.
  assign sel_idx     = lock_q ? lock_idx_q : pe_issue_idx;
  assign input_ready = free_found;
  assign id          = free_found ? RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx) : '0;
  assign output_id   = output_valid ? RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx) : '0;
  assign output_decode = decode_q[sel_idx];
  assign output_op_a   = opnd_q[sel_idx][0].value;
  assign output_op_b   = opnd_q[sel_idx][1].value;

  assign accept      = input_valid & input_ready;
  assign issue       = output_valid & output_ready;
  assign res_hit     = result_valid & (result_tag != '0);
  assign res_tag_ext = MaxTagWidth'(result_tag);
  assign lock_d      = output_valid & ~output_ready;
  assign lock_idx_d  = sel_idx;

  always_comb begin
    busy_d   = busy_q;
    opnd_d   = opnd_q;
    decode_d = decode_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (busy_q[i] && !opnd_q[i][k].present && res_hit && opnd_q[i][k].tag == res_tag_ext) begin
          opnd_d[i][k].present = 1'b1;
          opnd_d[i][k].value   = result_value;
        end
      end
    end
    if (issue) begin
      busy_d[sel_idx] = 1'b0;
    end
    if (accept) begin
      busy_d[free_idx]   = 1'b1;
      decode_d[free_idx] = op_decode;
      for (int k = 0; k < 2; k++) begin
        opnd_d[free_idx][k].value   = op_value[k];
        opnd_d[free_idx][k].present = op_value_valid[k];
        opnd_d[free_idx][k].tag     = MaxTagWidth'(op_tag[k]);
        // Result landing in the same cycle as dispatch would otherwise be missed.
        if (!op_value_valid[k] && res_hit && MaxTagWidth'(op_tag[k]) == res_tag_ext) begin
          opnd_d[free_idx][k].present = 1'b1;
          opnd_d[free_idx][k].value   = result_value;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        opnd_q[i]   <= '0;
        decode_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        opnd_q[i]   <= opnd_d[i];
        decode_q[i] <= decode_d[i];
      end
    end
  end

endmodule
